// File: rtl/truth_table_pkg.sv
// Shared types and constants for the exhaustive truth-table checker.
// Mask bit i is the expected F for input vector i, where the vector is {A,B,C,D} and A is the MSB.
package truth_table_pkg;

  localparam int TT_N_IN = 4;
  localparam int N_VEC   = 2**TT_N_IN;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  localparam logic [N_VEC-1:0] MASK_ALL_ZERO = 16'h0000;
  localparam logic [N_VEC-1:0] MASK_ALL_ONE  = 16'hFFFF;
  localparam logic [N_VEC-1:0] MASK_A        = 16'hFF00;
  localparam logic [N_VEC-1:0] MASK_D        = 16'hAAAA;
  localparam logic [N_VEC-1:0] MASK_B_XNOR_D = 16'hA5A5;

endpackage

// File: rtl/tt_settle_timer.sv
// Counts up the cycles a vector has been held and strobes settled_o on the last one.
module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic settled_o
);

  localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign settled_o = en_i && (cnt_q == W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors of a combinational DUT, samples F after a settle time and
// compares it against a truth table latched at start.
module truth_table_checker
  import truth_table_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail,
  output logic [2**N_IN-1:0]   captured
);

  localparam int NV = 2**N_IN;

  state_e          state_q, state_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [NV-1:0]   cap_q, cap_d;
  logic [N_IN:0]   fail_q, fail_d;
  logic [N_IN-1:0] first_q, first_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            pass_q, pass_d;
  logic            settled;

  // The counter is held at zero outside SETTLE, so every vector starts a fresh count.
  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q != ST_SETTLE),
    .en_i      (state_q == ST_SETTLE),
    .settled_o (settled)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    cap_d   = cap_q;
    fail_d  = fail_q;
    first_d = first_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          exp_d   = expected;
          cap_d   = '0;
          fail_d  = '0;
          first_d = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settled) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cap_d[vec_q] = f_in;
        if (f_in != exp_q[vec_q]) begin
          fail_d = fail_q + 1'b1;
          if (fail_q == '0) first_d = vec_q;
        end
        // pass is resolved here so it is already valid during the done cycle.
        if (vec_q == {N_IN{1'b1}}) begin
          pass_d  = (fail_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the latched table and captured results are reset too, since they are visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      cap_q   <= '0;
      fail_q  <= '0;
      first_q <= '0;
      vec_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      fail_q  <= fail_d;
      first_q <= first_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign fail_count = fail_q;
  assign first_fail = first_q;
  assign captured   = cap_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Randomized scoreboard bench: a reference model predicts each sweep's results and done time,
// and per-instance monitors compare whenever done is seen.
module tb_truth_table_checker;
  import truth_table_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start1, start3;
  logic [15:0] exp1, exp3, tt1, tt3;
  logic        f1, f3;
  logic [3:0]  vec1, vec3, ff1, ff3;
  logic        busy1, busy3, done1, done3, pass1, pass3;
  logic [4:0]  fc1, fc3;
  logic [15:0] cap1, cap3;

  // The behavioural DUT is a truth table looked up by the driven vector.
  assign f1 = tt1[vec1];
  assign f3 = tt3[vec3];

  truth_table_checker #(.N_IN(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .f_in(f1),
    .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail(ff1), .captured(cap1)
  );

  truth_table_checker #(.N_IN(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .f_in(f3),
    .vec_out(vec3), .busy(busy3), .done(done3), .pass(pass3),
    .fail_count(fc3), .first_fail(ff3), .captured(cap3)
  );

  typedef struct {
    logic [15:0] cap;
    logic [4:0]  fc;
    logic [3:0]  ff;
    logic        pass;
    int          e0;
    int          lat;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ndone1 = 0;
  int ndone3 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: mismatches are the set bits of tt^ex; first_fail is the lowest such index.
  function automatic exp_t model(input logic [15:0] tt, input logic [15:0] ex,
                                 input int e0, input int settle);
    exp_t e;
    logic [15:0] x;
    x = tt ^ ex;
    e.cap  = tt;
    e.fc   = 5'($countones(x));
    e.ff   = 4'd0;
    for (int i = 15; i >= 0; i--) if (x[i]) e.ff = 4'(i);
    e.pass = (x == 16'h0000);
    e.e0   = e0;
    e.lat  = 16 * (settle + 1);
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic [15:0] cap,
                         input logic [4:0] fc, input logic [3:0] ff, input logic ps,
                         input logic bsy);
    check({tag, "_done_time"}, 32'(cyc - e.e0), 32'(e.lat));
    check({tag, "_pass"}, 32'(ps), 32'(e.pass));
    check({tag, "_fail_count"}, 32'(fc), 32'(e.fc));
    check({tag, "_first_fail"}, 32'(ff), 32'(e.ff));
    check({tag, "_captured"}, 32'(cap), 32'(e.cap));
    check({tag, "_busy_in_done"}, 32'(bsy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done1) begin
      ndone1++;
      if (q1.size() == 0) flag("dut1_unexpected_done");
      else compare("dut1", q1.pop_front(), cap1, fc1, ff1, pass1, busy1);
    end
  end

  always @(negedge clk) begin
    if (rst_n && done3) begin
      ndone3++;
      if (q3.size() == 0) flag("dut3_unexpected_done");
      else compare("dut3", q3.pop_front(), cap3, fc3, ff3, pass3, busy3);
    end
  end

  // Issues start for one cycle; the edge that samples it is E0.
  task automatic begin_sweep1(input logic [15:0] tt, input logic [15:0] ex);
    @(negedge clk);
    tt1    = tt;
    exp1   = ex;
    start1 = 1'b1;
    q1.push_back(model(tt, ex, cyc + 1, 1));
    @(negedge clk);
    start1 = 1'b0;
    check("busy_after_start", 32'(busy1), 32'd1);
    check("vec_after_start", 32'(vec1), 32'd0);
  endtask

  task automatic wait_done1(input int n);
    int k = 0;
    while (ndone1 == n && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (ndone1 == n) flag("dut1_done_timeout");
  endtask

  task automatic sweep1(input logic [15:0] tt, input logic [15:0] ex);
    int n;
    n = ndone1;
    begin_sweep1(tt, ex);
    wait_done1(n);
  endtask

  task automatic check_zero1(input string tag);
    check({tag, "_vec"}, 32'(vec1), 32'd0);
    check({tag, "_busy"}, 32'(busy1), 32'd0);
    check({tag, "_done"}, 32'(done1), 32'd0);
    check({tag, "_pass"}, 32'(pass1), 32'd0);
    check({tag, "_fail_count"}, 32'(fc1), 32'd0);
    check({tag, "_first_fail"}, 32'(ff1), 32'd0);
    check({tag, "_captured"}, 32'(cap1), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    logic [15:0] tt;
    logic [15:0] ex;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    exp1   = '0;
    exp3   = '0;
    tt1    = MASK_B_XNOR_D;
    tt3    = MASK_B_XNOR_D;
    repeat (2) @(negedge clk);
    check_zero1("reset");
    check("reset_dut3_captured", 32'(cap3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios against the B xnor D function.
    sweep1(MASK_B_XNOR_D, MASK_B_XNOR_D);
    sweep1(MASK_B_XNOR_D, 16'h5A5A);
    sweep1(MASK_B_XNOR_D, 16'hA7A5);
    sweep1(MASK_B_XNOR_D, MASK_ALL_ZERO);
    sweep1(MASK_B_XNOR_D, MASK_ALL_ONE);

    // Restart attempts and expected-table changes during a sweep must be ignored.
    n = ndone1;
    begin_sweep1(MASK_B_XNOR_D, MASK_B_XNOR_D);
    repeat (8) @(negedge clk);
    start1 = 1'b1;
    exp1   = MASK_A;
    @(negedge clk);
    start1 = 1'b0;
    repeat (6) @(negedge clk);
    start1 = 1'b1;
    exp1   = MASK_D;
    @(negedge clk);
    start1 = 1'b0;
    wait_done1(n);
    repeat (40) @(negedge clk);
    check("single_done_count", 32'(ndone1), 32'(n + 1));

    // Asynchronous reset mid-sweep aborts without done.
    n = ndone1;
    begin_sweep1(MASK_B_XNOR_D, MASK_B_XNOR_D);
    k = 0;
    while (vec1 != 4'd7 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("reached_vec7", 32'(vec1), 32'd7);
    #2 rst_n = 1'b0;
    #1 check_zero1("async_reset");
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_abort", 32'(ndone1), 32'(n));
    sweep1(MASK_B_XNOR_D, MASK_B_XNOR_D);

    // Random functions with exact, single-bit-flipped or unrelated expected tables.
    for (int r = 0; r < 8; r++) begin
      tt = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       ex = tt;
        1:       ex = tt ^ (16'h0001 << $urandom_range(0, 15));
        default: ex = 16'($urandom);
      endcase
      sweep1(tt, ex);
    end

    // Longer settle time: vec_out advances every four cycles and done lands at E0+64.
    n = ndone3;
    @(negedge clk);
    tt3    = MASK_B_XNOR_D;
    exp3   = MASK_B_XNOR_D;
    start3 = 1'b1;
    q3.push_back(model(MASK_B_XNOR_D, MASK_B_XNOR_D, cyc + 1, 3));
    @(negedge clk);
    start3 = 1'b0;
    for (int j = 0; j < 64; j++) begin
      if (j % 4 == 1) check("settle3_vec_step", 32'(vec3), 32'(j / 4));
      @(negedge clk);
    end
    k = 0;
    while (ndone3 == n && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (ndone3 == n) flag("dut3_done_timeout");

    repeat (3) @(negedge clk);
    check("queue1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
